// File: rtl/ysyx_220066_mem_arbiter.sv
// Round-robin arbiter sharing one line read/write port between I-cache and D-cache.
// Optional bus watchdog is built when ARB_TIMEOUT_EN is defined.
module ysyx_220066_mem_arbiter #(
  parameter int AW      = 64,
  parameter int DW      = 128,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_rd_req,
  input  logic [AW-1:0] m0_rd_addr,
  output logic          m0_rd_ready,
  output logic          m0_rd_valid,
  output logic [DW-1:0] m0_rd_data,
  input  logic          m0_wr_req,
  input  logic [AW-1:0] m0_wr_addr,
  input  logic [DW-1:0] m0_wr_data,
  output logic          m0_wr_ready,
  input  logic          m1_rd_req,
  input  logic [AW-1:0] m1_rd_addr,
  output logic          m1_rd_ready,
  output logic          m1_rd_valid,
  output logic [DW-1:0] m1_rd_data,
  input  logic          m1_wr_req,
  input  logic [AW-1:0] m1_wr_addr,
  input  logic [DW-1:0] m1_wr_data,
  output logic          m1_wr_ready,
  output logic          mem_rd_req,
  output logic [AW-1:0] mem_rd_addr,
  input  logic          mem_rd_ready,
  input  logic          mem_rd_valid,
  input  logic [DW-1:0] mem_rd_data,
  output logic          mem_wr_req,
  output logic [AW-1:0] mem_wr_addr,
  output logic [DW-1:0] mem_wr_data,
  input  logic          mem_wr_ready
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_RD,
    BUSY_WR
  } state_t;

  state_t        state;
  logic          owner;
  logic          last;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;

  logic          p0;
  logic          p1;
  logic          gnt;
  logic          gnt_wr;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          rd_ok;
  logic          wr_ok;
  logic          tmo;
  logic          rd_fin;
  logic          wr_fin;

  assign p0 = m0_rd_req | m0_wr_req;
  assign p1 = m1_rd_req | m1_wr_req;

  // Contention goes to the master that did not win last time.
  assign gnt    = (p0 & p1) ? ~last : p1;
  assign gnt_wr = gnt ? m1_wr_req : m0_wr_req;

  // Dirty writeback goes ahead of the refill read.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    if (gnt) begin
      sel_addr  = gnt_wr ? m1_wr_addr : m1_rd_addr;
      sel_wdata = m1_wr_data;
    end else begin
      sel_addr  = gnt_wr ? m0_wr_addr : m0_rd_addr;
      sel_wdata = m0_wr_data;
    end
  end

  assign rd_ok = (state == BUSY_RD) & mem_rd_ready;
  assign wr_ok = (state == BUSY_WR) & mem_wr_ready;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CW-1:0] cnt;

  // cnt holds the number of BUSY cycles already elapsed before this one,
  // so the abort lands in the TIMEOUT-th BUSY cycle.
  assign tmo = (state != IDLE) & ~rd_ok & ~wr_ok
             & (cnt == CW'(TIMEOUT - 1));

  // Count BUSY cycles; held at zero while idle so each grant starts fresh.
  always_ff @(posedge clk) begin
    if (!rst || state == IDLE) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  // No watchdog: a silent bridge stalls the arbiter indefinitely.
  assign tmo = 1'b0 && (TIMEOUT > 0);
`endif

  assign rd_fin = rd_ok | (tmo & (state == BUSY_RD));
  assign wr_fin = wr_ok | (tmo & (state == BUSY_WR));

  assign mem_rd_req  = (state == BUSY_RD);
  assign mem_wr_req  = (state == BUSY_WR);
  assign mem_rd_addr = addr;
  assign mem_wr_addr = addr;
  assign mem_wr_data = wdata;

  assign m0_rd_ready = rd_fin & ~owner;
  assign m1_rd_ready = rd_fin & owner;
  assign m0_wr_ready = wr_fin & ~owner;
  assign m1_wr_ready = wr_fin & owner;

  assign m0_rd_valid = rd_ok & ~owner & mem_rd_valid;
  assign m1_rd_valid = rd_ok & owner & mem_rd_valid;
  assign m0_rd_data  = (rd_ok & ~owner) ? mem_rd_data : '0;
  assign m1_rd_data  = (rd_ok & owner) ? mem_rd_data : '0;

  // Grant from IDLE, hold the latched request until completion or abort.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      addr  <= '0;
      wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (p0 | p1) begin
            owner <= gnt;
            addr  <= sel_addr;
            if (gnt_wr) begin
              wdata <= sel_wdata;
              state <= BUSY_WR;
            end else begin
              state <= BUSY_RD;
            end
          end
        end
        BUSY_RD: begin
          if (rd_fin) begin
            state <= IDLE;
            last  <= owner;
          end
        end
        BUSY_WR: begin
          if (wr_fin) begin
            state <= IDLE;
            last  <= owner;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
